// File: rtl/din_packer.sv
// Serial-to-parallel sample packer: gathers UNR consecutive samples into one
// word (lane 0 = oldest), queues words in a small FIFO and delivers DLEN per run.
module din_packer #(
  parameter int DWIDTH = 14,
  parameter int UNR    = 4,
  parameter int DEPTH  = 4
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    START,
  input  logic [31:0]             DLEN,
  input  logic                    s_valid,
  input  logic [DWIDTH-1:0]       s_data,
  output logic                    s_ready,
  output logic [UNR*DWIDTH-1:0]   dout,
  output logic                    FIFO_VALID,
  input  logic                    SYNC_READY,
  output logic                    DONE,
  output logic [31:0]             WORD_CNT
);

  localparam int W  = UNR * DWIDTH;
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int LW = $clog2(UNR);
  localparam logic [LW-1:0] LANE_LAST = LW'(UNR - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FIN
  } state_t;

  state_t          state_q, state_d;
  logic            start_q;
  logic [31:0]     dlen_q, dlen_d;
  logic [31:0]     word_cnt_q, word_cnt_d;
  logic [31:0]     packed_q, packed_d;
  logic [LW-1:0]   lane_idx_q, lane_idx_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [W-1:0]    mem_q [DEPTH];

  logic            start_rise;
  logic            fifo_full;
  logic            fifo_empty;
  logic            ready_int;
  logic            valid_int;
  logic            accept;
  logic            push;
  logic            pop;
  logic [W-1:0]    push_word;

  assign start_rise = START & ~start_q;
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // Handshake qualifiers depend only on registered state, never on s_valid.
  assign ready_int = (state_q == ST_RUN) && !fifo_full && (packed_q < dlen_q);
  assign valid_int = (state_q == ST_RUN) && !fifo_empty;

  assign accept = s_valid & ready_int;
  assign push   = accept && (lane_idx_q == LANE_LAST);
  assign pop    = valid_int & SYNC_READY;

  // Lanes 0..UNR-2 are held in registers; the final lane comes straight from
  // s_data so the completed word is pushed in the same cycle it is finished.
  genvar gi;
  generate
    for (gi = 0; gi < UNR - 1; gi++) begin : g_lane
      logic [DWIDTH-1:0] lane_q;

      always_ff @(posedge CLK) begin
        if (RST) begin
          lane_q <= '0;
        end else if (accept && (lane_idx_q == LW'(gi))) begin
          lane_q <= s_data;
        end
      end

      assign push_word[gi*DWIDTH +: DWIDTH] = lane_q;
    end
  endgenerate

  assign push_word[(UNR-1)*DWIDTH +: DWIDTH] = s_data;

  // Storage needs no reset: emptiness is defined purely by the pointers.
  always_ff @(posedge CLK) begin
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= push_word;
    end
  end

  always_comb begin
    state_d    = state_q;
    dlen_d     = dlen_q;
    word_cnt_d = word_cnt_q;
    packed_d   = packed_q;
    lane_idx_d = lane_idx_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;

    if (accept) begin
      lane_idx_d = push ? '0 : lane_idx_q + LW'(1);
    end
    if (push) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
      packed_d = packed_q + 32'd1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
      if (word_cnt_q < dlen_q) begin
        word_cnt_d = word_cnt_q + 32'd1;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (start_rise) begin
          dlen_d     = DLEN;
          word_cnt_d = '0;
          packed_d   = '0;
          lane_idx_d = '0;
          wr_ptr_d   = '0;
          rd_ptr_d   = '0;
          state_d    = (DLEN == 32'd0) ? ST_FIN : ST_RUN;
        end
      end
      ST_RUN: begin
        if (!START) begin
          // Abort: drop queued words and any half-built word, keep the count.
          state_d    = ST_IDLE;
          lane_idx_d = '0;
          wr_ptr_d   = '0;
          rd_ptr_d   = '0;
        end else if (pop && (word_cnt_q == dlen_q - 32'd1)) begin
          state_d = ST_FIN;
        end
      end
      ST_FIN: begin
        if (!START) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      start_q    <= 1'b0;
      dlen_q     <= '0;
      word_cnt_q <= '0;
      packed_q   <= '0;
      lane_idx_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      start_q    <= START;
      dlen_q     <= dlen_d;
      word_cnt_q <= word_cnt_d;
      packed_q   <= packed_d;
      lane_idx_q <= lane_idx_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  assign s_ready    = ready_int;
  assign FIFO_VALID = valid_int;
  // Head is masked when not valid so dout reads zero after reset or abort.
  assign dout       = valid_int ? mem_q[rd_ptr_q[AW-1:0]] : '0;
  assign DONE       = (state_q == ST_FIN);
  assign WORD_CNT   = word_cnt_q;

endmodule

// File: tb/tb_din_packer.sv
// Self-checking bench for din_packer: accepted samples are grouped by a queue
// model into expected words, and every delivered word is compared in order.
module tb_din_packer;
  localparam int DW    = 14;
  localparam int UNR   = 4;
  localparam int DEPTH = 4;
  localparam int W     = DW * UNR;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          START = 1'b0;
  logic [31:0]   DLEN = '0;
  logic          s_valid = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic          s_ready;
  logic [W-1:0]  dout;
  logic          FIFO_VALID;
  logic          SYNC_READY = 1'b0;
  logic          DONE;
  logic [31:0]   WORD_CNT;

  int checks = 0;
  int errors = 0;

  // Reference model: samples accepted so far in the current word, and the
  // words that have been completed but not yet delivered.
  int           part_q[$];
  logic [W-1:0] exp_q[$];
  int           pops_m;
  int           acc_m;

  bit           a, p;
  logic [W-1:0] wd;

  din_packer #(.DWIDTH(DW), .UNR(UNR), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST(RST), .START(START), .DLEN(DLEN),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .dout(dout), .FIFO_VALID(FIFO_VALID), .SYNC_READY(SYNC_READY),
    .DONE(DONE), .WORD_CNT(WORD_CNT)
  );

  always #5 CLK = ~CLK;

  // Advance one clock: record the handshakes that complete at this edge,
  // update the model, then return 1 time unit after the edge.
  task automatic tick(output bit acc, output bit popped, output logic [W-1:0] word);
    logic [W-1:0] w;
    acc    = (s_valid === 1'b1) && (s_ready === 1'b1);
    popped = (FIFO_VALID === 1'b1) && (SYNC_READY === 1'b1);
    word   = dout;
    if (acc) begin
      acc_m++;
      part_q.push_back(int'(s_data));
      if (part_q.size() == UNR) begin
        w = '0;
        for (int k = 0; k < UNR; k++) w[k*DW +: DW] = DW'(part_q[k]);
        exp_q.push_back(w);
        part_q.delete();
      end
    end
    if (popped) begin
      pops_m++;
      $display("word %0d delivered: %h", pops_m, word);
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic model_new_run();
    part_q.delete();
    exp_q.delete();
    pops_m = 0;
    acc_m  = 0;
  endtask

  task automatic start_run(input logic [31:0] len);
    START = 1'b0;
    s_valid = 1'b0;
    tick(a, p, wd);
    DLEN = len;
    START = 1'b1;
    model_new_run();
    tick(a, p, wd);
    DLEN = 32'hDEAD_BEEF;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    tick(a, p, wd);
    tick(a, p, wd);
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL reset_s_ready: got %b expected 0", s_ready); end
    checks++; if (FIFO_VALID !== 1'b0) begin errors++; $display("FAIL reset_fifo_valid: got %b expected 0", FIFO_VALID); end
    checks++; if (DONE !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", DONE); end
    checks++; if (WORD_CNT !== 32'd0) begin errors++; $display("FAIL reset_word_cnt: got %0d expected 0", WORD_CNT); end
    checks++; if (dout !== '0) begin errors++; $display("FAIL reset_dout: got %h expected 0", dout); end
    RST = 1'b0;
    tick(a, p, wd);
  endtask

  task automatic test_basic();
    int idx;
    int fv;
    logic [W-1:0] first_w;
    start_run(32'd2);
    SYNC_READY = 1'b1;
    idx = 1;
    fv = 0;
    s_data = DW'(idx);
    s_valid = 1'b1;
    for (int cyc = 0; cyc < 40 && pops_m < 2; cyc++) begin
      if (FIFO_VALID === 1'b1) fv++;
      tick(a, p, wd);
      if (a) begin
        idx++;
        s_data = DW'(idx);
        if (idx > 8) s_valid = 1'b0;
      end
      if (p) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL basic_word: got %h expected none", wd); end
        else begin
          if (wd !== exp_q[0]) begin errors++; $display("FAIL basic_word: got %h expected %h", wd, exp_q[0]); end
          void'(exp_q.pop_front());
        end
        checks++; if (WORD_CNT !== 32'(pops_m)) begin errors++; $display("FAIL basic_word_cnt: got %0d expected %0d", WORD_CNT, pops_m); end
        if (pops_m == 2) begin
          checks++; if (DONE !== 1'b1) begin errors++; $display("FAIL basic_done_after_pop: got %b expected 1", DONE); end
        end
      end
    end
    first_w = '0;
    for (int k = 0; k < UNR; k++) first_w[k*DW +: DW] = DW'(k + 1);
    checks++; if (pops_m != 2) begin errors++; $display("FAIL basic_pops: got %0d expected 2", pops_m); end
    checks++; if (fv != 2) begin errors++; $display("FAIL basic_valid_cycles: got %0d expected 2", fv); end
    checks++; if (acc_m != 8) begin errors++; $display("FAIL basic_accepted: got %0d expected 8", acc_m); end
    for (int k = 0; k < 3; k++) tick(a, p, wd);
    checks++; if (DONE !== 1'b1) begin errors++; $display("FAIL basic_done_held: got %b expected 1", DONE); end
    checks++; if (WORD_CNT !== 32'd2) begin errors++; $display("FAIL basic_final_cnt: got %0d expected 2", WORD_CNT); end
    START = 1'b0;
    tick(a, p, wd);
    checks++; if (DONE !== 1'b0) begin errors++; $display("FAIL basic_done_drop: got %b expected 0", DONE); end
    SYNC_READY = 1'b0;
    // Words are also checked against a literal: the first run packs 1..4.
    s_data = '0;
    checks++; if (first_w !== {DW'(4), DW'(3), DW'(2), DW'(1)}) begin errors++; $display("FAIL basic_lane_order: got %h expected lane0=1", first_w); end
  endtask

  task automatic test_backpressure();
    bit have;
    bit stable;
    logic [W-1:0] ref_w;
    start_run(32'd8);
    SYNC_READY = 1'b0;
    s_valid = 1'b1;
    s_data = DW'($urandom);
    have = 1'b0;
    stable = 1'b1;
    ref_w = '0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      if (FIFO_VALID === 1'b1) begin
        if (!have) begin have = 1'b1; ref_w = dout; end
        else if (dout !== ref_w) stable = 1'b0;
      end
      tick(a, p, wd);
      if (a) s_data = DW'($urandom);
    end
    checks++; if (acc_m != UNR * DEPTH) begin errors++; $display("FAIL bp_fill_count: got %0d expected %0d", acc_m, UNR * DEPTH); end
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_full: got %b expected 0", s_ready); end
    checks++; if (FIFO_VALID !== 1'b1) begin errors++; $display("FAIL bp_valid_full: got %b expected 1", FIFO_VALID); end
    checks++; if (stable !== 1'b1) begin errors++; $display("FAIL bp_dout_stable: got %b expected 1", stable); end
    checks++; if (exp_q.size() == 0 || dout !== exp_q[0]) begin errors++; $display("FAIL bp_head: got %h expected first word", dout); end
    for (int cyc = 0; cyc < 400 && pops_m < 8; cyc++) begin
      SYNC_READY = 1'($urandom_range(0, 1));
      tick(a, p, wd);
      if (a) s_data = DW'($urandom);
      if (p) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL bp_word: got %h expected none", wd); end
        else begin
          if (wd !== exp_q[0]) begin errors++; $display("FAIL bp_word: got %h expected %h", wd, exp_q[0]); end
          void'(exp_q.pop_front());
        end
      end
    end
    SYNC_READY = 1'b1;
    for (int cyc = 0; cyc < 5; cyc++) tick(a, p, wd);
    checks++; if (pops_m != 8) begin errors++; $display("FAIL bp_pops: got %0d expected 8", pops_m); end
    checks++; if (acc_m != 8 * UNR) begin errors++; $display("FAIL bp_no_extra_samples: got %0d expected %0d", acc_m, 8 * UNR); end
    checks++; if (DONE !== 1'b1) begin errors++; $display("FAIL bp_done: got %b expected 1", DONE); end
    checks++; if (WORD_CNT !== 32'd8) begin errors++; $display("FAIL bp_word_cnt: got %0d expected 8", WORD_CNT); end
    s_valid = 1'b0;
    SYNC_READY = 1'b0;
    START = 1'b0;
    tick(a, p, wd);
  endtask

  task automatic test_stall();
    start_run(32'd1);
    SYNC_READY = 1'b1;
    s_valid = 1'b1;
    s_data = DW'($urandom);
    for (int cyc = 0; cyc < 10 && acc_m < 2; cyc++) begin
      tick(a, p, wd);
      if (a) s_data = DW'($urandom);
    end
    s_valid = 1'b0;
    for (int g = 0; g < 5; g++) begin
      checks++; if (FIFO_VALID !== 1'b0) begin errors++; $display("FAIL stall_gap_valid: got %b expected 0", FIFO_VALID); end
      tick(a, p, wd);
    end
    s_valid = 1'b1;
    for (int cyc = 0; cyc < 20 && pops_m < 1; cyc++) begin
      if (acc_m >= UNR) s_valid = 1'b0;
      tick(a, p, wd);
      if (a) s_data = DW'($urandom);
      if (p) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL stall_word: got %h expected none", wd); end
        else begin
          if (wd !== exp_q[0]) begin errors++; $display("FAIL stall_word: got %h expected %h", wd, exp_q[0]); end
          void'(exp_q.pop_front());
        end
      end
    end
    s_valid = 1'b1;
    for (int cyc = 0; cyc < 5; cyc++) tick(a, p, wd);
    s_valid = 1'b0;
    checks++; if (pops_m != 1) begin errors++; $display("FAIL stall_pops: got %0d expected 1", pops_m); end
    checks++; if (acc_m != UNR) begin errors++; $display("FAIL stall_accepted: got %0d expected %0d", acc_m, UNR); end
    checks++; if (DONE !== 1'b1) begin errors++; $display("FAIL stall_done: got %b expected 1", DONE); end
    START = 1'b0;
    SYNC_READY = 1'b0;
    tick(a, p, wd);
  endtask

  task automatic test_dlen_zero();
    int busy;
    START = 1'b0;
    tick(a, p, wd);
    DLEN = 32'd0;
    START = 1'b1;
    s_valid = 1'b1;
    SYNC_READY = 1'b1;
    model_new_run();
    tick(a, p, wd);
    checks++; if (DONE !== 1'b1) begin errors++; $display("FAIL zero_done: got %b expected 1", DONE); end
    busy = 0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      if (s_ready !== 1'b0 || FIFO_VALID !== 1'b0) busy++;
      tick(a, p, wd);
    end
    checks++; if (busy != 0) begin errors++; $display("FAIL zero_no_traffic: got %0d busy cycles expected 0", busy); end
    checks++; if (DONE !== 1'b1) begin errors++; $display("FAIL zero_done_held: got %b expected 1", DONE); end
    START = 1'b0;
    s_valid = 1'b0;
    SYNC_READY = 1'b0;
    tick(a, p, wd);
    checks++; if (DONE !== 1'b0) begin errors++; $display("FAIL zero_done_drop: got %b expected 0", DONE); end
  endtask

  task automatic test_abort();
    start_run(32'd10);
    SYNC_READY = 1'b1;
    s_valid = 1'b1;
    s_data = DW'($urandom);
    for (int cyc = 0; cyc < 40 && (acc_m < 3 * UNR + 2 || pops_m < 3); cyc++) begin
      if (acc_m >= 3 * UNR + 2) s_valid = 1'b0;
      tick(a, p, wd);
      if (a) s_data = DW'($urandom);
      if (p) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL abort_word: got %h expected none", wd); end
        else begin
          if (wd !== exp_q[0]) begin errors++; $display("FAIL abort_word: got %h expected %h", wd, exp_q[0]); end
          void'(exp_q.pop_front());
        end
      end
    end
    s_valid = 1'b0;
    SYNC_READY = 1'b0;
    checks++; if (acc_m != 3 * UNR + 2 || pops_m != 3) begin errors++; $display("FAIL abort_setup: got %0d samples %0d words expected %0d and 3", acc_m, pops_m, 3 * UNR + 2); end
    START = 1'b0;
    tick(a, p, wd);
    checks++; if (FIFO_VALID !== 1'b0) begin errors++; $display("FAIL abort_valid: got %b expected 0", FIFO_VALID); end
    checks++; if (DONE !== 1'b0) begin errors++; $display("FAIL abort_done: got %b expected 0", DONE); end
    checks++; if (WORD_CNT !== 32'd3) begin errors++; $display("FAIL abort_word_cnt: got %0d expected 3", WORD_CNT); end
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL abort_ready: got %b expected 0", s_ready); end
    start_run(32'd1);
    SYNC_READY = 1'b1;
    s_valid = 1'b1;
    s_data = DW'(9);
    for (int cyc = 0; cyc < 20 && pops_m < 1; cyc++) begin
      tick(a, p, wd);
      if (a) begin
        s_data = s_data + DW'(1);
        if (acc_m >= UNR) s_valid = 1'b0;
      end
      if (p) begin
        checks++;
        if (wd !== {DW'(12), DW'(11), DW'(10), DW'(9)}) begin errors++; $display("FAIL abort_rerun_word: got %h expected lanes 9,10,11,12", wd); end
      end
    end
    s_valid = 1'b1;
    for (int cyc = 0; cyc < 5; cyc++) tick(a, p, wd);
    s_valid = 1'b0;
    checks++; if (pops_m != 1) begin errors++; $display("FAIL abort_rerun_pops: got %0d expected 1", pops_m); end
    checks++; if (DONE !== 1'b1) begin errors++; $display("FAIL abort_rerun_done: got %b expected 1", DONE); end
    START = 1'b0;
    SYNC_READY = 1'b0;
    tick(a, p, wd);
  endtask

  task automatic test_reset_midrun();
    start_run(32'd4);
    SYNC_READY = 1'b0;
    s_valid = 1'b1;
    s_data = DW'($urandom);
    for (int cyc = 0; cyc < 20 && acc_m < 2 * UNR; cyc++) begin
      tick(a, p, wd);
      if (a) s_data = DW'($urandom);
    end
    s_valid = 1'b0;
    SYNC_READY = 1'b1;
    tick(a, p, wd);
    SYNC_READY = 1'b0;
    checks++; if (FIFO_VALID !== 1'b1 || WORD_CNT !== 32'd1) begin errors++; $display("FAIL rst_setup: got valid=%b cnt=%0d expected valid=1 cnt=1", FIFO_VALID, WORD_CNT); end
    RST = 1'b1;
    START = 1'b0;
    tick(a, p, wd);
    checks++; if (s_ready !== 1'b0 || FIFO_VALID !== 1'b0 || DONE !== 1'b0) begin errors++; $display("FAIL rst_mid_flags: got ready=%b valid=%b done=%b expected all 0", s_ready, FIFO_VALID, DONE); end
    checks++; if (WORD_CNT !== 32'd0) begin errors++; $display("FAIL rst_mid_word_cnt: got %0d expected 0", WORD_CNT); end
    checks++; if (dout !== '0) begin errors++; $display("FAIL rst_mid_dout: got %h expected 0", dout); end
    RST = 1'b0;
    tick(a, p, wd);
    start_run(32'd2);
    SYNC_READY = 1'b1;
    s_valid = 1'b1;
    s_data = DW'($urandom);
    for (int cyc = 0; cyc < 40 && pops_m < 2; cyc++) begin
      tick(a, p, wd);
      if (a) s_data = DW'($urandom);
      if (p) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL rst_rerun_word: got %h expected none", wd); end
        else begin
          if (wd !== exp_q[0]) begin errors++; $display("FAIL rst_rerun_word: got %h expected %h", wd, exp_q[0]); end
          void'(exp_q.pop_front());
        end
      end
    end
    s_valid = 1'b0;
    checks++; if (pops_m != 2 || DONE !== 1'b1) begin errors++; $display("FAIL rst_rerun_done: got %0d words done=%b expected 2 and 1", pops_m, DONE); end
    START = 1'b0;
    SYNC_READY = 1'b0;
    tick(a, p, wd);
  endtask

  task automatic test_random();
    int len;
    for (int run = 0; run < 4; run++) begin
      len = $urandom_range(1, 6);
      start_run(32'(len));
      s_data = DW'($urandom);
      for (int cyc = 0; cyc < 600 && pops_m < len; cyc++) begin
        s_valid = ($urandom_range(0, 9) < 7);
        SYNC_READY = ($urandom_range(0, 9) < 6);
        tick(a, p, wd);
        if (a) s_data = DW'($urandom);
        if (p) begin
          checks++;
          if (exp_q.size() == 0) begin errors++; $display("FAIL rand_word: got %h expected none", wd); end
          else begin
            if (wd !== exp_q[0]) begin errors++; $display("FAIL rand_word: got %h expected %h", wd, exp_q[0]); end
            void'(exp_q.pop_front());
          end
        end
      end
      s_valid = 1'b1;
      tick(a, p, wd);
      tick(a, p, wd);
      s_valid = 1'b0;
      checks++; if (pops_m != len) begin errors++; $display("FAIL rand_pops: got %0d expected %0d", pops_m, len); end
      checks++; if (acc_m != len * UNR) begin errors++; $display("FAIL rand_accepted: got %0d expected %0d", acc_m, len * UNR); end
      checks++; if (WORD_CNT !== 32'(len) || DONE !== 1'b1) begin errors++; $display("FAIL rand_end: got cnt=%0d done=%b expected cnt=%0d done=1", WORD_CNT, DONE, len); end
      START = 1'b0;
      SYNC_READY = 1'b0;
      tick(a, p, wd);
    end
  endtask

  initial begin
    model_new_run();
    test_reset();
    test_basic();
    test_backpressure();
    test_stall();
    test_dlen_zero();
    test_abort();
    test_reset_midrun();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
